permute_pipe: RTL

Pipelined, parametrised quadword shift/rotate unit for the odd (permute) pipe of each SPU core. It executes the twelve quadword shift, rotate and rotate-and-mask instructions on a `QW_BITS`-wide register value. Three registered stages sit between an elastic valid/ready input from issue and a valid/ready output to writeback. It supports backpressure, branch-mispredict flush and destination-tag passthrough.

---
 rtl/permute_pkg.sv | 42 ++++
 rtl/permute_decode.sv | 74 +++++++
 rtl/permute_pipe.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/permute_pkg.sv
// permute_pkg: opcodes, op classes and the decoded-op record for the quadword permute pipe.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package permute_pkg;

  // Register-count forms take the count from the preferred word of rb,
  // immediate forms take it from sign-extended imm7.
  localparam logic [10:0] OP_SHLQBI   = 11'b00111011011;
  localparam logic [10:0] OP_SHLQBII  = 11'b00111111011;
  localparam logic [10:0] OP_SHLQBY   = 11'b00111011111;
  localparam logic [10:0] OP_SHLQBYI  = 11'b00111111111;
  localparam logic [10:0] OP_ROTQBI   = 11'b00111011000;
  localparam logic [10:0] OP_ROTQBII  = 11'b00111111000;
  localparam logic [10:0] OP_ROTQBY   = 11'b00111011100;
  localparam logic [10:0] OP_ROTQBYI  = 11'b00111111100;
  localparam logic [10:0] OP_ROTQMBY  = 11'b00111011101;
  localparam logic [10:0] OP_ROTQMBYI = 11'b00111111101;
  localparam logic [10:0] OP_ROTQMBI  = 11'b00111011001;
  localparam logic [10:0] OP_ROTQMBII = 11'b00111111001;

  // Byte-count field is sized for quadwords up to 256 bytes wide.
  localparam int BYTE_CNT_W = 8;

  // SHL_BIT encodes as zero so a cleared record means "shift left by 0".
  typedef enum logic [2:0] {
    SHL_BIT  = 3'd0,
    SHL_BYTE = 3'd1,
    ROT_BIT  = 3'd2,
    ROT_BYTE = 3'd3,
    RSH_BYTE = 3'd4,
    RSH_BIT  = 3'd5,
    NOP_ZERO = 3'd6
  } op_class_e;

  typedef struct packed {
    op_class_e             cls;
    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [2:0]            bit_cnt;
    logic                  zero;
  } dec_op_t;

endpackage

// File: rtl/permute_decode.sv
// permute_decode: turns opcode + count source into class, byte count, bit count and zero-force.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
module permute_decode
  import permute_pkg::*;
#(
  parameter int QW_BITS = 128
) (
  input  logic [10:0] opcode_i,
  input  logic [31:0] rb_pref_i,
  input  logic [6:0]  imm7_i,
  output dec_op_t     dec_o
);

  // log2 of the quadword byte count; byte amounts live in cnt[LB-1:0].
  localparam int LB = $clog2(QW_BITS / 8);

  logic        use_imm;
  logic [31:0] cnt;
  logic [31:0] neg_cnt;
  logic        unused_cnt;

  // Pick the count source and form its 32-bit wrapping negation for the mask-rotate forms.
  always_comb begin
    case (opcode_i)
      OP_SHLQBII, OP_SHLQBYI, OP_ROTQBII,
      OP_ROTQBYI, OP_ROTQMBYI, OP_ROTQMBII: use_imm = 1'b1;
      default:                              use_imm = 1'b0;
    endcase
    cnt     = use_imm ? {{25{imm7_i[6]}}, imm7_i} : rb_pref_i;
    neg_cnt = 32'd0 - cnt;
  end

  // Only the low count bits matter; the rest are intentionally ignored.
  assign unused_cnt = ^{cnt[31:LB+1], neg_cnt[31:LB+1]};

  // Map each opcode onto a class plus the byte/bit amounts the two shifter stages consume.
  always_comb begin
    dec_o = '0;
    case (opcode_i)
      OP_SHLQBI, OP_SHLQBII: begin
        dec_o.cls     = SHL_BIT;
        dec_o.bit_cnt = cnt[2:0];
      end
      OP_SHLQBY, OP_SHLQBYI: begin
        dec_o.cls                = SHL_BYTE;
        dec_o.byte_cnt[LB-1:0]   = cnt[LB-1:0];
        dec_o.zero               = cnt[LB];
      end
      OP_ROTQBI, OP_ROTQBII: begin
        dec_o.cls     = ROT_BIT;
        dec_o.bit_cnt = cnt[2:0];
      end
      OP_ROTQBY, OP_ROTQBYI: begin
        dec_o.cls              = ROT_BYTE;
        dec_o.byte_cnt[LB-1:0] = cnt[LB-1:0];
      end
      OP_ROTQMBY, OP_ROTQMBYI: begin
        dec_o.cls              = RSH_BYTE;
        dec_o.byte_cnt[LB-1:0] = neg_cnt[LB-1:0];
        dec_o.zero             = neg_cnt[LB];
      end
      OP_ROTQMBI, OP_ROTQMBII: begin
        dec_o.cls     = RSH_BIT;
        dec_o.bit_cnt = neg_cnt[2:0];
      end
      default: begin
        dec_o.cls  = NOP_ZERO;
        dec_o.zero = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/permute_pipe.sv
// permute_pipe: 3-stage quadword shift/rotate unit (S1 decode, S2 byte shift, S3 bit shift).
// Latency: 3 cycles, 1 op/cycle; holds up to 3 ops when writeback stalls.
// Backpressure: valid/ready both sides; in_ready is combinational from out_ready.
// Optional: PERMUTE_ILLEGAL_TRAP_EN adds out_illegal, flagging undefined opcodes.
module permute_pipe
  import permute_pkg::*;
#(
  parameter int QW_BITS = 128,
  parameter int TAG_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [10:0]        opcode,
  input  logic [QW_BITS-1:0] ra,
  input  logic [QW_BITS-1:0] rb,
  input  logic [6:0]         imm7,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [QW_BITS-1:0] result,
  output logic [TAG_W-1:0]   out_tag
`ifdef PERMUTE_ILLEGAL_TRAP_EN
  ,
  output logic               out_illegal
`endif
);

  dec_op_t            s1_op_d;
  logic               unused_rb;

  logic               s1_vld_q;
  dec_op_t            s1_op_q;
  logic [QW_BITS-1:0] s1_ra_q;
  logic [TAG_W-1:0]   s1_tag_q;

  logic               s2_vld_q;
  logic [QW_BITS-1:0] s2_dat_d;
  logic [QW_BITS-1:0] s2_dat_q;
  op_class_e          s2_cls_q;
  logic [2:0]         s2_bit_q;
  logic [TAG_W-1:0]   s2_tag_q;

  logic               s3_vld_q;
  logic [QW_BITS-1:0] s3_dat_d;
  logic [QW_BITS-1:0] s3_dat_q;
  logic [TAG_W-1:0]   s3_tag_q;

  logic               s1_adv;
  logic               s2_adv;
  logic               s3_adv;
  logic [31:0]        byte_sh;
  logic [31:0]        bit_sh;

  permute_decode #(
    .QW_BITS (QW_BITS)
  ) u_decode (
    .opcode_i  (opcode),
    .rb_pref_i (rb[QW_BITS-1 -: 32]),
    .imm7_i    (imm7),
    .dec_o     (s1_op_d)
  );

  // Only the preferred word of rb carries the count.
  assign unused_rb = ^rb[QW_BITS-33:0];

  // A stage moves when it is empty or its successor moves; the chain starts at writeback.
  always_comb begin
    s3_adv = !s3_vld_q || out_ready;
    s2_adv = !s2_vld_q || s3_adv;
    s1_adv = !s1_vld_q || s2_adv;
  end

  assign in_ready  = s1_adv;
  assign out_valid = s3_vld_q;
  assign result    = s3_dat_q;
  assign out_tag   = s3_tag_q;

  // S1: capture the decoded op, operand and tag; flush drops whatever is presented.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_vld_q <= 1'b0;
      s1_op_q  <= '0;
      s1_ra_q  <= '0;
      s1_tag_q <= '0;
    end else begin
      if (flush)       s1_vld_q <= 1'b0;
      else if (s1_adv) s1_vld_q <= in_valid;
      if (s1_adv) begin
        s1_op_q  <= s1_op_d;
        s1_ra_q  <= ra;
        s1_tag_q <= in_tag;
      end
    end
  end

  // Byte shifter: whole-byte left shift, left rotate or right shift, with zero-force on overrange.
  always_comb begin
    byte_sh  = 32'(s1_op_q.byte_cnt) << 3;
    s2_dat_d = s1_ra_q;
    case (s1_op_q.cls)
      SHL_BYTE: s2_dat_d = s1_ra_q << byte_sh;
      ROT_BYTE: s2_dat_d = (s1_ra_q << byte_sh) | (s1_ra_q >> (QW_BITS - byte_sh));
      RSH_BYTE: s2_dat_d = s1_ra_q >> byte_sh;
      default:  s2_dat_d = s1_ra_q;
    endcase
    if (s1_op_q.zero) s2_dat_d = '0;
  end

  // S2: hold the byte-shifted data plus what the bit stage still needs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_vld_q <= 1'b0;
      s2_dat_q <= '0;
      s2_cls_q <= SHL_BIT;
      s2_bit_q <= '0;
      s2_tag_q <= '0;
    end else begin
      if (flush)       s2_vld_q <= 1'b0;
      else if (s2_adv) s2_vld_q <= s1_vld_q;
      if (s2_adv) begin
        s2_dat_q <= s2_dat_d;
        s2_cls_q <= s1_op_q.cls;
        s2_bit_q <= s1_op_q.bit_cnt;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  // Bit shifter: 0-7 bit left shift, full-width left rotate (MSB wraps to LSB) or right shift.
  always_comb begin
    bit_sh   = 32'(s2_bit_q);
    s3_dat_d = s2_dat_q;
    case (s2_cls_q)
      SHL_BIT: s3_dat_d = s2_dat_q << bit_sh;
      ROT_BIT: s3_dat_d = (s2_dat_q << bit_sh) | (s2_dat_q >> (QW_BITS - bit_sh));
      RSH_BIT: s3_dat_d = s2_dat_q >> bit_sh;
      default: s3_dat_d = s2_dat_q;
    endcase
  end

  // S3: output register; stays put while writeback stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3_vld_q <= 1'b0;
      s3_dat_q <= '0;
      s3_tag_q <= '0;
    end else begin
      if (flush)       s3_vld_q <= 1'b0;
      else if (s3_adv) s3_vld_q <= s2_vld_q;
      if (s3_adv) begin
        s3_dat_q <= s3_dat_d;
        s3_tag_q <= s2_tag_q;
      end
    end
  end

`ifdef PERMUTE_ILLEGAL_TRAP_EN
  logic s2_ill_q;
  logic s3_ill_q;

  // Carry the undefined-opcode flag alongside the data so it lines up with result.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_ill_q <= 1'b0;
      s3_ill_q <= 1'b0;
    end else begin
      if (s2_adv) s2_ill_q <= (s1_op_q.cls == NOP_ZERO);
      if (s3_adv) s3_ill_q <= s2_ill_q;
    end
  end

  assign out_illegal = s3_ill_q;
`endif

endmodule
